// File: rtl/busperm_pkg.sv
// Shared constants and types for the bus-permutator control loader.
// Holds the word/byte widths, slot and word types, and the assembler state encoding.
package busperm_pkg;

    localparam int CTRL_W = 16;
    localparam int BYTE_W = 8;

    typedef logic [CTRL_W-1:0] ctrl_word_t;
    typedef logic [1:0]        slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        WRITE = 2'd2
    } asm_state_t;

endpackage

// File: rtl/busperm_cfg_asm.sv
// Byte assembler: turns low/high configuration bytes into one table write strobe.
// Flags short (last on byte 0) and long (no last on byte 1) words with a one-cycle error pulse.
import busperm_pkg::*;

module busperm_cfg_asm #(
    parameter int BYTE_W = busperm_pkg::BYTE_W,
    parameter int SLOT_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [BYTE_W-1:0]   cfg_data_i,
    input  logic                cfg_last_i,
    input  logic [SLOT_W-1:0]   cfg_slot_i,
    output logic                wr_en_o,
    output logic [SLOT_W-1:0]   wr_slot_o,
    output logic [2*BYTE_W-1:0] wr_word_o,
    output logic                cfg_err_o
);

    asm_state_t          state_q, state_d;
    logic                run_q;
    logic                err_q, err_d;
    logic [BYTE_W-1:0]   low_q, high_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                xfer;
    logic                lo_cap, hi_cap;

    // run_q keeps the loader closed while in reset and opens it on the first clock after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (cfg_last_i) err_d   = 1'b1;
                    else            state_d = HIGH;
                end
            end
            HIGH: begin
                if (xfer) begin
                    if (cfg_last_i) begin
                        state_d = WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready_o = run_q && (state_q != WRITE);
        xfer        = cfg_valid_i && cfg_ready_o;
        wr_en_o     = (state_q == WRITE);
        lo_cap      = xfer && (state_q == IDLE) && !cfg_last_i;
        hi_cap      = xfer && (state_q == HIGH) && cfg_last_i;
    end

    // Word holding registers need no reset: the FSM restarts in IDLE and only WRITE consumes them.
    always_ff @(posedge clk) begin
        if (lo_cap) begin
            low_q  <= cfg_data_i;
            slot_q <= cfg_slot_i;
        end
        if (hi_cap) begin
            high_q <= cfg_data_i;
        end
    end

    assign wr_slot_o = slot_q;
    assign wr_word_o = {high_q, low_q};
    assign cfg_err_o = err_q;

endmodule

// File: rtl/busperm_ctrl_loader.sv
// Control-word front-end for the 8x4-bit bus permutator: slot table plus frame-synchronous output.
// The permutator control only changes on frame_start, reading the table before any same-cycle write.
import busperm_pkg::*;

module busperm_ctrl_loader #(
    parameter int CTRL_W = busperm_pkg::CTRL_W,
    parameter int BYTE_W = busperm_pkg::BYTE_W,
    parameter int SLOTS  = 4,
    localparam int SLOT_W = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [BYTE_W-1:0] cfg_data,
    input  logic              cfg_last,
    input  logic [SLOT_W-1:0] cfg_slot,
    input  logic              frame_start,
    input  logic [SLOT_W-1:0] sel_slot,
    output logic [CTRL_W-1:0] control,
    output logic [SLOT_W-1:0] active_slot,
    output logic              cfg_err
);

    if (CTRL_W != 2 * BYTE_W) begin : g_bad_width
        $error("CTRL_W must equal 2*BYTE_W");
    end
    if (SLOTS != (1 << SLOT_W)) begin : g_bad_slots
        $error("SLOTS must be a power of two");
    end

    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;
    logic [CTRL_W-1:0] wr_word;

    logic [CTRL_W-1:0] table_q [SLOTS];
    logic [CTRL_W-1:0] control_q;
    logic [SLOT_W-1:0] active_q;

    busperm_cfg_asm #(
        .BYTE_W (BYTE_W),
        .SLOT_W (SLOT_W)
    ) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_data_i  (cfg_data),
        .cfg_last_i  (cfg_last),
        .cfg_slot_i  (cfg_slot),
        .wr_en_o     (wr_en),
        .wr_slot_o   (wr_slot),
        .wr_word_o   (wr_word),
        .cfg_err_o   (cfg_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                table_q[i] <= '0;
            end
        end else if (wr_en) begin
            table_q[wr_slot] <= wr_word;
        end
    end

    // Same-edge table write and frame read: the read sees the pre-write entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control_q <= '0;
            active_q  <= '0;
        end else if (frame_start) begin
            control_q <= table_q[sel_slot];
            active_q  <= sel_slot;
        end
    end

    assign control     = control_q;
    assign active_slot = active_q;

endmodule

// File: tb/tb_busperm_ctrl_loader.sv
// Directed bench for busperm_ctrl_loader: per-cycle vector table plus a mid-word reset sequence.
module tb_busperm_ctrl_loader;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_data;
    logic        cfg_last;
    logic [1:0]  cfg_slot;
    logic        frame_start;
    logic [1:0]  sel_slot;
    logic [15:0] control;
    logic [1:0]  active_slot;
    logic        cfg_err;

    int checks;
    int failures;

    busperm_ctrl_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_last    (cfg_last),
        .cfg_slot    (cfg_slot),
        .frame_start (frame_start),
        .sel_slot    (sel_slot),
        .control     (control),
        .active_slot (active_slot),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [1:0]  s;
        logic        fs;
        logic [1:0]  sel;
        logic        rdy;
        logic [15:0] ctrl;
        logic [1:0]  act;
        logic        err;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [1:0] s,
                         input logic fs, input logic [1:0] sel);
        cfg_valid   = v;
        cfg_data    = d;
        cfg_last    = l;
        cfg_slot    = s;
        frame_start = fs;
        sel_slot    = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            v  d      l  s  fs sel  rdy ctrl      act err
        vecs[0]  = '{0, 8'h00, 0, 0, 0, 0,   1, 16'h0000, 0, 0};
        vecs[1]  = '{1, 8'hA5, 0, 2, 0, 0,   1, 16'h0000, 0, 0};
        vecs[2]  = '{1, 8'h3C, 1, 0, 0, 0,   1, 16'h0000, 0, 0};
        vecs[3]  = '{0, 8'h00, 0, 0, 0, 0,   0, 16'h0000, 0, 0};
        vecs[4]  = '{0, 8'h00, 0, 0, 1, 2,   1, 16'h3CA5, 2, 0};
        vecs[5]  = '{1, 8'h11, 0, 0, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[6]  = '{1, 8'h11, 1, 0, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[7]  = '{1, 8'h34, 0, 1, 0, 0,   0, 16'h3CA5, 2, 0};
        vecs[8]  = '{1, 8'h34, 0, 1, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[9]  = '{1, 8'h12, 1, 0, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[10] = '{1, 8'h78, 0, 3, 0, 0,   0, 16'h3CA5, 2, 0};
        vecs[11] = '{1, 8'h78, 0, 3, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[12] = '{1, 8'h56, 1, 0, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[13] = '{0, 8'h00, 0, 0, 0, 0,   0, 16'h3CA5, 2, 0};
        vecs[14] = '{0, 8'h00, 0, 0, 1, 0,   1, 16'h1111, 0, 0};
        vecs[15] = '{0, 8'h00, 0, 0, 1, 1,   1, 16'h1234, 1, 0};
        vecs[16] = '{0, 8'h00, 0, 0, 1, 3,   1, 16'h5678, 3, 0};
        vecs[17] = '{0, 8'h00, 0, 0, 1, 2,   1, 16'h3CA5, 2, 0};
        vecs[18] = '{1, 8'hFF, 1, 0, 0, 0,   1, 16'h3CA5, 2, 1};
        vecs[19] = '{0, 8'h00, 0, 0, 0, 0,   1, 16'h3CA5, 2, 0};
        vecs[20] = '{0, 8'h00, 0, 0, 1, 0,   1, 16'h1111, 0, 0};
        vecs[21] = '{1, 8'hAA, 0, 0, 0, 0,   1, 16'h1111, 0, 0};
        vecs[22] = '{1, 8'hBB, 0, 0, 0, 0,   1, 16'h1111, 0, 1};
        vecs[23] = '{1, 8'h22, 0, 0, 0, 0,   1, 16'h1111, 0, 0};
        vecs[24] = '{1, 8'h33, 1, 0, 0, 0,   1, 16'h1111, 0, 0};
        vecs[25] = '{0, 8'h00, 0, 0, 0, 0,   0, 16'h1111, 0, 0};
        vecs[26] = '{0, 8'h00, 0, 0, 1, 0,   1, 16'h3322, 0, 0};
        vecs[27] = '{1, 8'hEF, 0, 1, 0, 0,   1, 16'h3322, 0, 0};
        vecs[28] = '{1, 8'hBE, 1, 0, 0, 0,   1, 16'h3322, 0, 0};
        vecs[29] = '{0, 8'h00, 0, 0, 1, 1,   0, 16'h1234, 1, 0};
        vecs[30] = '{0, 8'h00, 0, 0, 1, 1,   1, 16'hBEEF, 1, 0};

        rst_n = 1'b0;
        drive(0, 8'h00, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset ready", {15'd0, cfg_ready}, 16'd0);
        chk("reset control", control, 16'h0000);
        chk("reset active", {14'd0, active_slot}, 16'd0);
        chk("reset err", {15'd0, cfg_err}, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("ready after release", {15'd0, cfg_ready}, 16'd1);

        // Each vector: inputs set after an edge, ready checked before the next edge,
        // registered outputs checked after it.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].s, vecs[i].fs, vecs[i].sel);
            #1;
            chk($sformatf("vec%0d ready", i), {15'd0, cfg_ready}, {15'd0, vecs[i].rdy});
            tick();
            chk($sformatf("vec%0d control", i), control, vecs[i].ctrl);
            chk($sformatf("vec%0d active", i), {14'd0, active_slot}, {14'd0, vecs[i].act});
            chk($sformatf("vec%0d err", i), {15'd0, cfg_err}, {15'd0, vecs[i].err});
        end

        // Reset between the low and high byte of a word bound for slot 2.
        drive(1, 8'h99, 0, 2, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", {15'd0, cfg_ready}, 16'd0);
        chk("midrst control", control, 16'h0000);
        chk("midrst active", {14'd0, active_slot}, 16'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("midrst err%0d", k), {15'd0, cfg_err}, 16'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("midrst ready after", {15'd0, cfg_ready}, 16'd1);
        chk("midrst err after", {15'd0, cfg_err}, 16'd0);
        drive(0, 8'h00, 0, 0, 1, 2);
        tick();
        chk("midrst slot2 cleared", control, 16'h0000);
        chk("midrst active2", {14'd0, active_slot}, 16'd2);
        drive(0, 8'h00, 0, 0, 1, 1);
        tick();
        chk("midrst slot1 cleared", control, 16'h0000);
        drive(1, 8'h55, 0, 2, 0, 0);
        tick();
        chk("reload err lo", {15'd0, cfg_err}, 16'd0);
        drive(1, 8'h44, 1, 0, 0, 0);
        tick();
        chk("reload err hi", {15'd0, cfg_err}, 16'd0);
        drive(0, 8'h00, 0, 0, 0, 0);
        #1;
        chk("reload write ready", {15'd0, cfg_ready}, 16'd0);
        tick();
        chk("reload hold", control, 16'h0000);
        drive(0, 8'h00, 0, 0, 1, 2);
        tick();
        chk("reload control", control, 16'h4455);
        chk("reload active", {14'd0, active_slot}, 16'd2);
        drive(0, 8'h00, 0, 0, 0, 0);
        tick();
        chk("reload holds", control, 16'h4455);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
